// File: rtl/uart_pkg.sv
// Shared receiver types, default parameter constants and sizing helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rxState_t;

  localparam int unsigned DEF_DATA_BITS      = 8;
  localparam int unsigned DEF_STOP_BIT_TICKS = 16;
  localparam int unsigned DEF_BAUD_RATE      = 19200;
  localparam int unsigned DEF_CLOCK_RATE     = 50000000;
  localparam int unsigned DEF_SAMPLE_RATE    = 16;

  // Clocks per oversampling tick, integer truncated.
  function automatic int unsigned calcDivisor(input int unsigned clockRate,
                                              input int unsigned baudRate,
                                              input int unsigned sampleRate);
    return clockRate / (baudRate * sampleRate);
  endfunction

  // Bits needed to hold values 0..maxVal (at least one).
  function automatic int unsigned widthFor(input int unsigned maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

  function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversampling tick generator: one-clock pulse every DIVISOR clocks.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_RATE  = DEF_CLOCK_RATE,
  parameter int unsigned BAUD_RATE   = DEF_BAUD_RATE,
  parameter int unsigned SAMPLE_RATE = DEF_SAMPLE_RATE
) (
  input  logic Clock,
  input  logic ResetN,
  output logic SampleTick
);

  localparam int unsigned DIVISOR = calcDivisor(CLOCK_RATE, BAUD_RATE, SAMPLE_RATE);
  localparam int unsigned CW      = widthFor(DIVISOR - 1);
  localparam logic [CW-1:0] LAST  = CW'(DIVISOR - 1);

  logic [CW-1:0] count;

  // Count 0..DIVISOR-1, wrap, and pulse the tick on the wrap.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      count      <= '0;
      SampleTick <= 1'b0;
    end else if (count == LAST) begin
      count      <= '0;
      SampleTick <= 1'b1;
    end else begin
      count      <= count + 1'b1;
      SampleTick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit glitch rejection, LSB-first data, framing check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS      = DEF_DATA_BITS,
  parameter int unsigned STOP_BIT_TICKS = DEF_STOP_BIT_TICKS,
  parameter int unsigned BAUD_RATE      = DEF_BAUD_RATE,
  parameter int unsigned CLOCK_RATE     = DEF_CLOCK_RATE,
  parameter int unsigned SAMPLE_RATE    = DEF_SAMPLE_RATE
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxDone,
  output logic                 FramingError,
  output logic                 SampleTick
);

  localparam int unsigned SW = widthFor(maxOf(SAMPLE_RATE - 1, STOP_BIT_TICKS - 1));
  localparam int unsigned NW = widthFor(DATA_BITS - 1);
  localparam logic [SW-1:0] S_HALF = SW'(SAMPLE_RATE / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(SAMPLE_RATE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(STOP_BIT_TICKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  logic                 rxSync1, rxSync2;
  rxState_t             state, stateNext;
  logic [SW-1:0]        s, sNext;
  logic [NW-1:0]        n, nNext;
  logic [DATA_BITS-1:0] shiftReg, shiftNext;
  logic [DATA_BITS-1:0] dataNext;
  logic                 feNext, doneNext;

  uart_baud_gen #(
    .CLOCK_RATE (CLOCK_RATE),
    .BAUD_RATE  (BAUD_RATE),
    .SAMPLE_RATE(SAMPLE_RATE)
  ) baudGen (
    .Clock     (Clock),
    .ResetN    (ResetN),
    .SampleTick(SampleTick)
  );

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      rxSync1 <= 1'b1;
      rxSync2 <= 1'b1;
    end else begin
      rxSync1 <= Rx;
      rxSync2 <= rxSync1;
    end
  end

  // FSM, counters, shift register and output registers.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      shiftReg     <= '0;
      RxData       <= '0;
      FramingError <= 1'b0;
      RxDone       <= 1'b0;
    end else begin
      state        <= stateNext;
      s            <= sNext;
      n            <= nNext;
      shiftReg     <= shiftNext;
      RxData       <= dataNext;
      FramingError <= feNext;
      RxDone       <= doneNext;
    end
  end

  // Next-state and output logic; outputs only change on the stop-bit sample.
  always_comb begin
    stateNext = state;
    sNext     = s;
    nNext     = n;
    shiftNext = shiftReg;
    dataNext  = RxData;
    feNext    = FramingError;
    doneNext  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxSync2) begin
          stateNext = START;
          sNext     = '0;
        end
      end
      START: begin
        if (SampleTick) begin
          if (s == S_HALF) begin
            sNext = '0;
            if (!rxSync2) begin
              stateNext = DATA;
              nNext     = '0;
            end else begin
              stateNext = IDLE;
            end
          end else begin
            sNext = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (SampleTick) begin
          if (s == S_BIT) begin
            sNext     = '0;
            shiftNext = (shiftReg >> 1) | (DATA_BITS'(rxSync2) << (DATA_BITS - 1));
            if (n == N_LAST) begin
              stateNext = STOP;
            end else begin
              nNext = n + 1'b1;
            end
          end else begin
            sNext = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (SampleTick) begin
          if (s == S_STOP) begin
            sNext     = '0;
            dataNext  = shiftReg;
            feNext    = ~rxSync2;
            doneNext  = 1'b1;
            stateNext = IDLE;
          end else begin
            sNext = s + 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx: one default-rate instance, one fast instance.
module tb_uart_rx;

  localparam int BIT0      = 162 * 16;
  localparam int FAST_CLK  = 19200 * 16 * 4;
  localparam int BIT1      = 4 * 16;

  logic       clk = 1'b0;
  logic       rst0, rst1, rx0, rx1;
  logic [7:0] data0, data1;
  logic       done0, done1, fe0, fe1, tick0, tick1;

  int checks   = 0;
  int failures = 0;

  logic [8:0] obs0[$], obs1[$], exp0[$], exp1[$];
  logic       prevDone0 = 1'b0, prevDone1 = 1'b0;
  logic       prevFe0 = 1'b0, prevFe1 = 1'b0;
  logic [7:0] prevData0 = '0, prevData1 = '0;

  always #5 clk = ~clk;

  uart_rx u0 (
    .Clock(clk), .ResetN(rst0), .Rx(rx0), .RxData(data0), .RxDone(done0),
    .FramingError(fe0), .SampleTick(tick0)
  );

  uart_rx #(.CLOCK_RATE(FAST_CLK)) u1 (
    .Clock(clk), .ResetN(rst1), .Rx(rx1), .RxData(data1), .RxDone(done1),
    .FramingError(fe1), .SampleTick(tick1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Record frames and check pulse width / output stability on the default instance.
  always @(negedge clk) begin
    if (rst0 && done0) begin
      obs0.push_back({fe0, data0});
      check("u0 done width", 32'(prevDone0), 0);
    end
    if (rst0 && (data0 !== prevData0 || fe0 !== prevFe0))
      check("u0 output change without done", 32'(done0), 1);
    prevDone0 = done0; prevData0 = data0; prevFe0 = fe0;
  end

  // Same monitoring for the fast instance.
  always @(negedge clk) begin
    if (rst1 && done1) begin
      obs1.push_back({fe1, data1});
      check("u1 done width", 32'(prevDone1), 0);
    end
    if (rst1 && (data1 !== prevData1 || fe1 !== prevFe1))
      check("u1 output change without done", 32'(done1), 1);
    prevDone1 = done1; prevData1 = data1; prevFe1 = fe1;
  end

  task automatic waitClocks(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic setRx(input int which, input logic v);
    if (which == 0) rx0 = v;
    else rx1 = v;
  endtask

  function automatic logic tickOf(input int which);
    return (which == 0) ? tick0 : tick1;
  endfunction

  // Reference model: a frame yields its data byte, with framing error iff the stop bit is low.
  task automatic sendFrame(input int which, input logic [7:0] data, input bit stopOk);
    int bitClks;
    bitClks = (which == 0) ? BIT0 : BIT1;
    setRx(which, 1'b0);
    waitClocks(bitClks);
    for (int i = 0; i < 8; i++) begin
      setRx(which, data[i]);
      waitClocks(bitClks);
    end
    if (stopOk) begin
      setRx(which, 1'b1);
      waitClocks(bitClks);
    end else begin
      setRx(which, 1'b0);
      waitClocks(bitClks * 3 / 4);
      setRx(which, 1'b1);
      waitClocks(bitClks * 5 / 4);
    end
    if (which == 0) exp0.push_back({~stopOk, data});
    else exp1.push_back({~stopOk, data});
  endtask

  task automatic checkFrames(input int which, input string tag);
    logic [8:0] o[$];
    logic [8:0] e[$];
    int k;
    if (which == 0) begin
      o = obs0; e = exp0; obs0.delete(); exp0.delete();
    end else begin
      o = obs1; e = exp1; obs1.delete(); exp1.delete();
    end
    check({tag, " frame count"}, o.size(), e.size());
    k = (o.size() < e.size()) ? o.size() : e.size();
    for (int i = 0; i < k; i++) begin
      check($sformatf("%s frame%0d data", tag, i), 32'(o[i][7:0]), 32'(e[i][7:0]));
      check($sformatf("%s frame%0d ferr", tag, i), 32'(o[i][8]), 32'(e[i][8]));
    end
  endtask

  task automatic measurePeriod(input int which, input int expected, input string tag);
    bit seen;
    int cnt;
    seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (tickOf(which)) seen = 1;
    end
    check({tag, " first tick"}, 32'(seen), 1);
    @(negedge clk);
    check({tag, " tick width"}, 32'(tickOf(which)), 0);
    cnt = 1;
    seen = 0;
    while (cnt < 1000 && !seen) begin
      @(negedge clk);
      cnt++;
      if (tickOf(which)) seen = 1;
    end
    check({tag, " tick period"}, cnt, expected);
  endtask

  initial begin
    logic [7:0] rdata;
    bit         rok;
    rst0 = 1'b0; rst1 = 1'b0; rx0 = 1'b1; rx1 = 1'b1;
    waitClocks(3);
    check("reset u0 RxData", 32'(data0), 0);
    check("reset u0 RxDone", 32'(done0), 0);
    check("reset u0 FramingError", 32'(fe0), 0);
    check("reset u0 SampleTick", 32'(tick0), 0);
    check("reset u1 RxData", 32'(data1), 0);
    check("reset u1 SampleTick", 32'(tick1), 0);
    rst0 = 1'b1; rst1 = 1'b1;

    measurePeriod(0, 162, "u0");
    measurePeriod(1, 4, "u1");

    // 0x55 at the default rate.
    sendFrame(0, 8'h55, 1'b1);
    waitClocks(100);
    checkFrames(0, "u0 0x55");

    // Start-bit glitch of 3 ticks.
    rx1 = 1'b0;
    waitClocks(3 * 4);
    rx1 = 1'b1;
    waitClocks(200);
    checkFrames(1, "glitch");
    check("glitch state idle", 32'(u1.state), 32'(uart_pkg::IDLE));
    check("glitch RxData kept", 32'(data1), 0);

    // Stop bit low.
    sendFrame(1, 8'hA3, 1'b0);
    waitClocks(50);
    checkFrames(1, "bad stop");

    // Back-to-back frames with zero idle.
    sendFrame(1, 8'hA3, 1'b1);
    sendFrame(1, 8'h0F, 1'b1);
    waitClocks(50);
    checkFrames(1, "back-to-back");

    // Reset in the middle of data bit 4.
    rx1 = 1'b0;
    waitClocks(BIT1);
    for (int i = 0; i < 4; i++) begin
      rx1 = i[0];
      waitClocks(BIT1);
    end
    rx1 = 1'b1;
    waitClocks(BIT1 / 2);
    rst1 = 1'b0;
    waitClocks(2);
    check("midreset RxData", 32'(data1), 0);
    check("midreset RxDone", 32'(done1), 0);
    check("midreset FramingError", 32'(fe1), 0);
    check("midreset SampleTick", 32'(tick1), 0);
    rst1 = 1'b1;
    waitClocks(BIT1 * 20);
    checkFrames(1, "midreset");
    sendFrame(1, 8'h3C, 1'b1);
    waitClocks(50);
    checkFrames(1, "after reset 0x3C");

    // Random frames with random stop validity and idle gaps.
    for (int f = 0; f < 10; f++) begin
      rdata = 8'($urandom_range(0, 255));
      rok   = ($urandom_range(0, 3) != 0);
      sendFrame(1, rdata, rok);
      waitClocks($urandom_range(0, 2) * 40);
    end
    waitClocks(50);
    checkFrames(1, "random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: data bits per frame.
REQ-002 SHALL have parameter STOP_BIT_TICKS, default 16: sample ticks spent in the stop bit.
REQ-003 SHALL have parameter BAUD_RATE, default 19200: line bit rate.
REQ-004 SHALL have parameter CLOCK_RATE, default 50000000: Clock frequency in Hz.
REQ-005 SHALL have parameter SAMPLE_RATE, default 16: sample ticks per bit.
REQ-006 SHALL have port Clock, input, 1 bit: single system clock, rising edge.
REQ-007 SHALL have port ResetN, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port Rx, input, 1 bit: asynchronous serial line, idle high.
REQ-009 SHALL have port RxData, output, DATA_BITS bits: last received byte.
REQ-010 SHALL have port RxDone, output, 1 bit: one-cycle pulse when RxData updates; this port drives the RX FIFO write.
REQ-011 SHALL have port FramingError, output, 1 bit: stop bit sampled low on the last completed frame.
REQ-012 SHALL have port SampleTick, output, 1 bit: internal oversampling tick, exposed for debug.

Function
REQ-013 SHALL pass Rx through a 2-flop synchronizer; all decisions use the synchronized value (2-clock input latency).
REQ-014 SHALL compute DIVISOR = CLOCK_RATE/(BAUD_RATE*SAMPLE_RATE), integer truncated (162 at defaults).
REQ-015 SHALL pulse SampleTick for one Clock every DIVISOR clocks, free-running, with the counter wrapping DIVISOR-1 -> 0.
REQ-016 SHALL implement FSM states IDLE, START, DATA, STOP, with a sample counter s and a bit counter n.
REQ-017 SHALL move IDLE -> START on synchronized Rx=0, clearing s, independent of SampleTick.
REQ-018 SHALL, in START on a tick with s==SAMPLE_RATE/2-1, go to DATA (s=0, n=0) if Rx=0, else return to IDLE (glitch rejection); otherwise s++ on each tick.
REQ-019 SHALL, in DATA on a tick with s==SAMPLE_RATE-1, set s=0 and shift Rx in LSB-first; go to STOP when n==DATA_BITS-1, else n++.
REQ-020 SHALL, in STOP on a tick with s==STOP_BIT_TICKS-1, load RxData from the shift register, set FramingError=~Rx, pulse RxDone for exactly one Clock, and go to IDLE.
REQ-021 SHALL hold RxData and FramingError stable between RxDone pulses.
REQ-022 SHALL pulse RxDone even on a framing error, so that data with FramingError=1 still reaches the FIFO.
REQ-023 SHALL allow a new start bit to be detected on the first clock after returning to IDLE (back-to-back frames).
REQ-024 SHALL keep counters s and n within their ranges, with no wrap-around beyond the terminal values above.

Reset
REQ-025 SHALL, on ResetN=0, asynchronously set the FSM to IDLE, s=0, n=0, the baud counter to 0, the shift register to 0, RxData=0, RxDone=0, FramingError=0, SampleTick=0, and both synchronizer flops to 1.
REQ-026 SHALL abandon any partial frame on a mid-frame reset and emit no RxDone for it.

Structure
REQ-027 SHALL place the state enum (IDLE/START/DATA/STOP) and default parameter constants in shared package uart_pkg.
REQ-028 SHALL instantiate sub-module uart_baud_gen (parameters CLOCK_RATE, BAUD_RATE, SAMPLE_RATE; ports Clock, ResetN, SampleTick) as the tick generator.

Verification
REQ-029 SHALL verify: frame 0x55 at 19200 baud, valid stop -> one RxDone, RxData=0x55, FramingError=0.
REQ-030 SHALL verify: Rx low for 3 ticks then high -> no RxDone, FSM back in IDLE, RxData unchanged.
REQ-031 SHALL verify: frame 0xA3 with stop bit held low -> RxDone, RxData=0xA3, FramingError=1.
REQ-032 SHALL verify: frames 0xA3 then 0x0F back-to-back (zero idle) -> two RxDone pulses, data correct in order.
REQ-033 SHALL verify: ResetN asserted during data bit 4 -> all outputs 0, no RxDone; next frame 0x3C received correctly.
REQ-034 SHALL verify: SampleTick period equals exactly 162 Clocks at default parameters.
